pwm_burst_sequencer: RTL

//  Runtime-programmable two-phase burst PWM generator with soft-start and latched fault.

---
 rtl/pwm_burst_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_burst_sequencer.sv
// Two-phase burst PWM generator (A burst then B burst) with soft-start ramp of the B burst length
// and a latched fault. Define PWM_BURST_COMPL_EN for a dead-time-protected complementary output.
module pwm_burst_sequencer #(
  parameter int CNT_W    = 24,
  parameter int PULSE_W  = 8,
  parameter int SS_W     = 16,
  parameter int DEADTIME = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   period_a,
  input  logic [CNT_W-1:0]   duty_a,
  input  logic [PULSE_W-1:0] pulses_a,
  input  logic [CNT_W-1:0]   period_b,
  input  logic [CNT_W-1:0]   duty_b,
  input  logic [PULSE_W-1:0] pulses_b,
  input  logic [SS_W-1:0]    ss_step,
  input  logic               fault_in,
  input  logic               fault_clr,
  output logic               pwm_out,
`ifdef PWM_BURST_COMPL_EN
  output logic               pwm_out_n,
`endif
  output logic [2:0]         state_out,
  output logic               burst_done,
  output logic               fault_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SS_A  = 3'd1,
    SS_B  = 3'd2,
    RUN_A = 3'd3,
    RUN_B = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [7:0] DT = 8'(DEADTIME);

  state_t             state;
  logic [CNT_W-1:0]   cnt, sh_period_a, sh_duty_a, sh_period_b, sh_duty_b;
  logic [PULSE_W-1:0] pcnt, sh_pulses_a, sh_pulses_b, ss_target, ss_len;
  logic [SS_W-1:0]    ss_timer, sh_ss_step;

  logic               is_a, is_b, in_ss, zero_phase, raw;
  logic               period_end, burst_end, ss_tick, latch_cfg;
  logic [CNT_W-1:0]   per, duty;
  logic [PULSE_W-1:0] target, pcnt_nx;

  assign state_out = state;
  assign pcnt_nx   = pcnt + PULSE_W'(1);

  always_comb begin
    is_a  = (state == SS_A) || (state == RUN_A);
    is_b  = (state == SS_B) || (state == RUN_B);
    in_ss = (state == SS_A) || (state == SS_B);
    per   = is_a ? sh_period_a : sh_period_b;
    if (per == '0) per = CNT_W'(1);
    duty  = is_a ? sh_duty_a : sh_duty_b;
    if (is_a)               target = (sh_pulses_a == '0) ? PULSE_W'(1) : sh_pulses_a;
    else if (state == SS_B) target = ss_len;
    else                    target = sh_pulses_b;
    // An empty B phase still occupies one clock so the sequence always advances.
    zero_phase = is_b && (target == '0);
    raw        = (is_a || is_b) && !zero_phase && (cnt < duty);
    period_end = zero_phase || (cnt == per);
    burst_end  = zero_phase || (period_end && (pcnt_nx == target));
    ss_tick    = in_ss && (sh_ss_step != '0) && (ss_timer == sh_ss_step - SS_W'(1));
    latch_cfg  = !fault_in && enable && ((state == IDLE) || (is_b && burst_end));
  end

  // Shadow configuration: refreshed only when an A phase begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period_a <= '0;
      sh_duty_a   <= '0;
      sh_pulses_a <= '0;
      sh_period_b <= '0;
      sh_duty_b   <= '0;
      sh_pulses_b <= '0;
      sh_ss_step  <= '0;
    end else if (latch_cfg) begin
      sh_period_a <= period_a;
      sh_duty_a   <= duty_a;
      sh_pulses_a <= pulses_a;
      sh_period_b <= period_b;
      sh_duty_b   <= duty_b;
      sh_pulses_b <= pulses_b;
      sh_ss_step  <= ss_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pcnt       <= '0;
      ss_timer   <= '0;
      ss_target  <= '0;
      ss_len     <= '0;
      burst_done <= 1'b0;
      fault_out  <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (fault_in) begin
        state     <= FAULT;
        fault_out <= 1'b1;
        cnt       <= '0;
        pcnt      <= '0;
        ss_timer  <= '0;
        ss_target <= '0;
      end else begin
        case (state)
          IDLE: if (enable) begin
            state <= (ss_step == '0) ? RUN_A : SS_A;
            cnt   <= '0;
            pcnt  <= '0;
          end
          FAULT: if (fault_clr) begin
            state     <= IDLE;
            fault_out <= 1'b0;
          end
          default: begin
            if (in_ss && (sh_ss_step != '0)) begin
              ss_timer <= ss_tick ? '0 : ss_timer + SS_W'(1);
              if (ss_tick && (ss_target < sh_pulses_b)) ss_target <= ss_target + PULSE_W'(1);
            end
            if (!period_end) begin
              cnt <= cnt + CNT_W'(1);
            end else if (!enable) begin
              state     <= IDLE;
              cnt       <= '0;
              pcnt      <= '0;
              ss_timer  <= '0;
              ss_target <= '0;
            end else if (!burst_end) begin
              cnt  <= '0;
              pcnt <= pcnt_nx;
            end else begin
              cnt  <= '0;
              pcnt <= '0;
              case (state)
                SS_A: begin
                  state  <= SS_B;
                  ss_len <= ss_target;
                end
                SS_B:    state <= (ss_len >= sh_pulses_b) ? RUN_A : SS_A;
                RUN_A:   state <= RUN_B;
                default: begin
                  state      <= RUN_A;
                  burst_done <= 1'b1;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

`ifdef PWM_BURST_COMPL_EN
  logic [7:0] hi_run, lo_run;

  // Each output needs DT consecutive cycles of its raw level, so the two can never overlap.
  always_ff @(posedge clk) begin
    if (rst || fault_in || !(is_a || is_b)) begin
      hi_run    <= '0;
      lo_run    <= '0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      hi_run    <= raw ? ((hi_run < DT) ? hi_run + 8'd1 : hi_run) : 8'd0;
      lo_run    <= !raw ? ((lo_run < DT) ? lo_run + 8'd1 : lo_run) : 8'd0;
      pwm_out   <= raw && (hi_run >= DT);
      pwm_out_n <= !raw && (lo_run >= DT);
    end
  end
`else
  logic unused_dt;
  assign unused_dt = ^DT;

  always_ff @(posedge clk) begin
    if (rst || fault_in) pwm_out <= 1'b0;
    else                 pwm_out <= raw;
  end
`endif

endmodule
